// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB plus 2-bit counter BHT for fetch-stage lookup,
// with EX-stage resolution, mispredict/redirect generation and saturating statistics.
module branch_predictor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned BTB_ENTRIES = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    input  logic            i_ex_valid,
    input  logic [6:0]      i_ex_opcode,
    input  logic [2:0]      i_ex_funct3,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_rs1_dout,
    input  logic [XLEN-1:0] i_ex_imm,
    input  logic            i_ex_cmp_eq,
    input  logic            i_ex_cmp_lt,
    input  logic            i_ex_cmp_ltu,
    input  logic            i_ex_pred_taken,
    input  logic [XLEN-1:0] i_ex_pred_target,
    output logic            o_branch_taken,
    output logic [XLEN-1:0] o_pc_branch,
    output logic            o_mispredict,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic [31:0]     o_branch_cnt,
    output logic [31:0]     o_mispredict_cnt
);

    localparam int unsigned BHT_W = $clog2(BHT_ENTRIES);
    localparam int unsigned BTB_W = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - BTB_W - 2;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [BTB_ENTRIES-1:0] r_btb_valid;
    logic [BTB_ENTRIES-1:0] r_btb_jump;
    logic [TAG_W-1:0]       r_btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_btb_target [BTB_ENTRIES];
    logic [1:0]             r_bht        [BHT_ENTRIES];
    logic [31:0]            r_branch_cnt;
    logic [31:0]            r_mispredict_cnt;

    logic [BHT_W-1:0] w_if_bht_idx;
    logic [BTB_W-1:0] w_if_btb_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [XLEN-1:0]  w_if_pc_plus4;

    logic [BHT_W-1:0] w_ex_bht_idx;
    logic [BTB_W-1:0] w_ex_btb_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic [XLEN-1:0]  w_ex_pc_imm;
    logic [XLEN-1:0]  w_ex_jalr_tgt;
    logic [XLEN-1:0]  w_ex_pc_plus4;
    logic             w_is_cf;
    logic             w_is_branch;
    logic             w_taken;
    logic [XLEN-1:0]  w_target;
    logic [1:0]       w_ctr_next;

    // Fetch-stage lookup on registered state; no bypass from a same-cycle update
    assign w_if_bht_idx  = i_if_pc[BHT_W+1:2];
    assign w_if_btb_idx  = i_if_pc[BTB_W+1:2];
    assign w_if_tag      = i_if_pc[XLEN-1:BTB_W+2];
    assign w_if_pc_plus4 = i_if_pc + XLEN'(4);
    assign w_if_hit      = r_btb_valid[w_if_btb_idx] && (r_btb_tag[w_if_btb_idx] == w_if_tag);
    assign o_pred_taken  = !i_reset && w_if_hit &&
                           (r_btb_jump[w_if_btb_idx] || r_bht[w_if_bht_idx][1]);
    assign o_pred_target = o_pred_taken ? r_btb_target[w_if_btb_idx] : w_if_pc_plus4;

    assign w_ex_bht_idx  = i_ex_pc[BHT_W+1:2];
    assign w_ex_btb_idx  = i_ex_pc[BTB_W+1:2];
    assign w_ex_tag      = i_ex_pc[XLEN-1:BTB_W+2];
    assign w_ex_pc_imm   = i_ex_pc + i_ex_imm;
    assign w_ex_jalr_tgt = (i_ex_rs1_dout + i_ex_imm) & ~XLEN'(1);
    assign w_ex_pc_plus4 = i_ex_pc + XLEN'(4);

    // EX-stage resolution of actual direction and target
    always_comb begin
        w_is_cf     = 1'b0;
        w_is_branch = 1'b0;
        w_taken     = 1'b0;
        w_target    = '0;
        if (i_ex_valid) begin
            case (i_ex_opcode)
                OP_JAL: begin
                    w_is_cf  = 1'b1;
                    w_taken  = 1'b1;
                    w_target = w_ex_pc_imm;
                end
                OP_JALR: begin
                    if (i_ex_funct3 == 3'b000) begin
                        w_is_cf  = 1'b1;
                        w_taken  = 1'b1;
                        w_target = w_ex_jalr_tgt;
                    end
                end
                OP_BRANCH: begin
                    w_is_cf     = 1'b1;
                    w_is_branch = 1'b1;
                    w_target    = w_ex_pc_imm;
                    case (i_ex_funct3)
                        3'b000:  w_taken = i_ex_cmp_eq;
                        3'b001:  w_taken = !i_ex_cmp_eq;
                        3'b100:  w_taken = i_ex_cmp_lt;
                        3'b101:  w_taken = !i_ex_cmp_lt;
                        3'b110:  w_taken = i_ex_cmp_ltu;
                        3'b111:  w_taken = !i_ex_cmp_ltu;
                        default: begin
                            w_is_cf     = 1'b0;
                            w_is_branch = 1'b0;
                            w_target    = '0;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign o_branch_taken = w_taken;
    assign o_pc_branch    = w_target;
    assign o_mispredict   = i_ex_valid &&
                            ((w_taken != i_ex_pred_taken) ||
                             (w_taken && (w_target != i_ex_pred_target)));
    assign o_redirect_pc  = !i_ex_valid ? '0 : (w_taken ? w_target : w_ex_pc_plus4);

    // Saturating 2-bit counter step for the resolving branch
    always_comb begin
        w_ctr_next = r_bht[w_ex_bht_idx];
        if (w_taken) begin
            if (w_ctr_next != 2'b11) w_ctr_next = w_ctr_next + 2'b01;
        end else begin
            if (w_ctr_next != 2'b00) w_ctr_next = w_ctr_next - 2'b01;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btb_valid  <= '0;
            r_btb_jump   <= '0;
            r_btb_tag    <= '{default: '0};
            r_btb_target <= '{default: '0};
            r_bht        <= '{default: 2'b01};
        end else if (w_is_cf) begin
            if (w_is_branch) r_bht[w_ex_bht_idx] <= w_ctr_next;
            if (w_taken) begin
                r_btb_valid[w_ex_btb_idx]  <= 1'b1;
                r_btb_jump[w_ex_btb_idx]   <= !w_is_branch;
                r_btb_tag[w_ex_btb_idx]    <= w_ex_tag;
                r_btb_target[w_ex_btb_idx] <= w_target;
            end
        end
    end

    // Statistics, saturating at all-ones
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_is_cf && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + 32'd1;
            if (o_mispredict && (r_mispredict_cnt != '1))
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
        end
    end

    assign o_branch_cnt     = r_branch_cnt;
    assign o_mispredict_cnt = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: table of resolve vectors plus multi-cycle
// sequences covering counter saturation, BTB aliasing, gating and async reset.
module tb_branch_predictor;

    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] ALU = 7'b0110011;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_ex_valid;
    logic [6:0]  i_ex_opcode;
    logic [2:0]  i_ex_funct3;
    logic [31:0] i_ex_pc;
    logic [31:0] i_ex_rs1_dout;
    logic [31:0] i_ex_imm;
    logic        i_ex_cmp_eq;
    logic        i_ex_cmp_lt;
    logic        i_ex_cmp_ltu;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic        o_branch_taken;
    logic [31:0] o_pc_branch;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_branch_cnt;
    logic [31:0] o_mispredict_cnt;

    int total = 0;
    int bad = 0;

    branch_predictor #(.XLEN(32), .BHT_ENTRIES(64), .BTB_ENTRIES(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_if_pc(i_if_pc),
        .o_pred_taken(o_pred_taken), .o_pred_target(o_pred_target),
        .i_ex_valid(i_ex_valid), .i_ex_opcode(i_ex_opcode), .i_ex_funct3(i_ex_funct3),
        .i_ex_pc(i_ex_pc), .i_ex_rs1_dout(i_ex_rs1_dout), .i_ex_imm(i_ex_imm),
        .i_ex_cmp_eq(i_ex_cmp_eq), .i_ex_cmp_lt(i_ex_cmp_lt), .i_ex_cmp_ltu(i_ex_cmp_ltu),
        .i_ex_pred_taken(i_ex_pred_taken), .i_ex_pred_target(i_ex_pred_target),
        .o_branch_taken(o_branch_taken), .o_pc_branch(o_pc_branch),
        .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
        .o_branch_cnt(o_branch_cnt), .o_mispredict_cnt(o_mispredict_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        pt;
        logic [31:0] ptgt;
        logic        x_taken;
        logic [31:0] x_pcb;
        logic        x_mis;
        logic [31:0] x_redir;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm,
                         input logic eq, input logic lt, input logic ltu,
                         input logic pt, input logic [31:0] ptgt);
        i_ex_valid = v; i_ex_opcode = op; i_ex_funct3 = f3; i_ex_pc = pc;
        i_ex_rs1_dout = rs1; i_ex_imm = imm; i_ex_cmp_eq = eq; i_ex_cmp_lt = lt;
        i_ex_cmp_ltu = ltu; i_ex_pred_taken = pt; i_ex_pred_target = ptgt;
    endtask

    // Let one edge commit the driven EX instruction, then park EX idle
    task automatic tick();
        @(posedge i_clk);
        #1;
        i_ex_valid = 1'b0;
    endtask

    task automatic check_lookup(input string name, input logic [31:0] pc,
                                input logic taken, input logic [31:0] tgt);
        i_if_pc = pc;
        #1;
        check({name, "_taken"}, 32'(o_pred_taken), 32'(taken));
        check({name, "_target"}, o_pred_target, tgt);
    endtask

    task automatic check_cnt(input string name, input int b, input int m);
        check({name, "_branch_cnt"}, o_branch_cnt, 32'(b));
        check({name, "_mispred_cnt"}, o_mispredict_cnt, 32'(m));
    endtask

    initial begin
        //        op    f3    pc            rs1          imm          eq lt ltu pt ptgt          tk pcb           mis redir
        vecs[0]  = '{BR,   3'd0, 32'h200,      32'h0,       32'h40,      1, 0, 0, 0, 32'h0,       1, 32'h240,      1, 32'h240};
        vecs[1]  = '{BR,   3'd1, 32'h200,      32'h0,       32'h40,      1, 0, 0, 0, 32'h0,       0, 32'h240,      0, 32'h204};
        vecs[2]  = '{BR,   3'd4, 32'h200,      32'h0,       32'h40,      0, 1, 0, 1, 32'h240,     1, 32'h240,      0, 32'h240};
        vecs[3]  = '{BR,   3'd5, 32'h200,      32'h0,       32'h40,      0, 1, 0, 0, 32'h0,       0, 32'h240,      0, 32'h204};
        vecs[4]  = '{BR,   3'd6, 32'h200,      32'h0,       32'h40,      0, 0, 0, 1, 32'h240,     0, 32'h240,      1, 32'h204};
        vecs[5]  = '{BR,   3'd7, 32'h200,      32'h0,       32'h40,      0, 0, 0, 1, 32'h300,     1, 32'h240,      1, 32'h240};
        vecs[6]  = '{BR,   3'd2, 32'h200,      32'h0,       32'h40,      1, 1, 1, 0, 32'h0,       0, 32'h0,        0, 32'h204};
        vecs[7]  = '{JAL,  3'd0, 32'h1000,     32'h0,       32'hFFFFFFF0,0, 0, 0, 0, 32'h0,       1, 32'hFF0,      1, 32'hFF0};
        vecs[8]  = '{JALR, 3'd0, 32'h300,      32'h1001,    32'h4,       0, 0, 0, 1, 32'h1004,    1, 32'h1004,     0, 32'h1004};
        vecs[9]  = '{JALR, 3'd1, 32'h500,      32'h1001,    32'h4,       0, 0, 0, 1, 32'h1004,    0, 32'h0,        1, 32'h504};
        vecs[10] = '{ALU,  3'd0, 32'h600,      32'h0,       32'h8,       1, 1, 1, 0, 32'h0,       0, 32'h0,        0, 32'h604};
        vecs[11] = '{JAL,  3'd0, 32'hFFFFFFFC, 32'h0,       32'h8,       0, 0, 0, 1, 32'h4,       1, 32'h4,        0, 32'h4};
        vecs[12] = '{ALU,  3'd0, 32'hFFFFFFFC, 32'h0,       32'h0,       0, 0, 0, 0, 32'h0,       0, 32'h0,        0, 32'h0};

        i_reset = 1'b1;
        i_if_pc = 32'h100;
        drive(0, ALU, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0);
        #1;
        check_lookup("during_reset", 32'h100, 0, 32'h104);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
        check_lookup("reset_lookup", 32'h100, 0, 32'h104);
        check_cnt("reset", 0, 0);

        // Pure resolve checks; valid is dropped before every edge so no state changes
        for (int i = 0; i < 13; i++) begin
            @(negedge i_clk);
            drive(1, vecs[i].op, vecs[i].f3, vecs[i].pc, vecs[i].rs1, vecs[i].imm,
                  vecs[i].eq, vecs[i].lt, vecs[i].ltu, vecs[i].pt, vecs[i].ptgt);
            #1;
            check($sformatf("v%0d_taken", i), 32'(o_branch_taken), 32'(vecs[i].x_taken));
            check($sformatf("v%0d_pc_branch", i), o_pc_branch, vecs[i].x_pcb);
            check($sformatf("v%0d_mispredict", i), 32'(o_mispredict), 32'(vecs[i].x_mis));
            check($sformatf("v%0d_redirect", i), o_redirect_pc, vecs[i].x_redir);
            i_ex_valid = 1'b0;
        end
        @(negedge i_clk);
        check_cnt("after_table", 0, 0);

        // Taken BEQ installs BTB entry; counter 1 -> 2; same-cycle lookup sees old state
        drive(1, BR, 3'd0, 32'h200, 32'h0, 32'h40, 1, 0, 0, 0, 32'h0);
        check_lookup("beq_same_cycle", 32'h200, 0, 32'h204);
        tick();
        check_lookup("beq_after", 32'h200, 1, 32'h240);
        check_cnt("beq", 1, 1);

        // Three not-taken: 2 -> 1 -> 0 -> 0, then a fourth at 0
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            drive(1, BR, 3'd0, 32'h200, 32'h0, 32'h40, 0, 0, 0, 0, 32'h0);
            tick();
        end
        check_lookup("beq_sat0", 32'h200, 0, 32'h204);
        @(negedge i_clk);
        drive(1, BR, 3'd0, 32'h200, 32'h0, 32'h40, 0, 0, 0, 0, 32'h0);
        #1;
        check("beq_nt4_mispredict", 32'(o_mispredict), 32'd0);
        tick();
        // One taken from 0 gives 1 (still not taken), second gives 2 (taken)
        @(negedge i_clk);
        drive(1, BR, 3'd0, 32'h200, 32'h0, 32'h40, 1, 0, 0, 0, 32'h0);
        tick();
        check_lookup("beq_ctr1", 32'h200, 0, 32'h204);
        @(negedge i_clk);
        drive(1, BR, 3'd0, 32'h200, 32'h0, 32'h40, 1, 0, 0, 0, 32'h0);
        tick();
        check_lookup("beq_ctr2", 32'h200, 1, 32'h240);
        check_cnt("beq_seq", 7, 3);

        // JALR installs a jump entry; funct3!=0 JALR is not control flow
        @(negedge i_clk);
        drive(1, JALR, 3'd0, 32'h300, 32'h1001, 32'h4, 0, 0, 0, 1, 32'h1004);
        #1;
        check("jalr_mispredict", 32'(o_mispredict), 32'd0);
        tick();
        check_lookup("jalr_lookup", 32'h300, 1, 32'h1004);
        @(negedge i_clk);
        drive(1, JALR, 3'd1, 32'h300, 32'h1001, 32'h4, 0, 0, 0, 1, 32'h1004);
        #1;
        check("jalr_f3_mispredict", 32'(o_mispredict), 32'd1);
        check("jalr_f3_redirect", o_redirect_pc, 32'h304);
        tick();
        check_lookup("jalr_f3_lookup", 32'h300, 1, 32'h1004);
        check_cnt("jalr", 8, 4);

        // Aliasing: 0x0 and 0x40 share BTB index 0
        @(negedge i_clk);
        drive(1, JAL, 3'd0, 32'h0, 32'h0, 32'h80, 0, 0, 0, 0, 32'h0);
        tick();
        check_lookup("alias_first", 32'h0, 1, 32'h80);
        @(negedge i_clk);
        drive(1, JAL, 3'd0, 32'h40, 32'h0, 32'h100, 0, 0, 0, 0, 32'h0);
        tick();
        check_lookup("alias_evicted", 32'h0, 0, 32'h4);
        check_lookup("alias_second", 32'h40, 1, 32'h140);
        check_cnt("alias", 10, 6);

        // Invalid EX branch: no outputs, no update, no stats
        @(negedge i_clk);
        drive(0, BR, 3'd0, 32'h0, 32'h0, 32'h80, 1, 0, 0, 1, 32'h0);
        #1;
        check("invalid_taken", 32'(o_branch_taken), 32'd0);
        check("invalid_mispredict", 32'(o_mispredict), 32'd0);
        check("invalid_redirect", o_redirect_pc, 32'h0);
        tick();
        check_lookup("invalid_lookup", 32'h0, 0, 32'h4);
        check_cnt("invalid", 10, 6);

        // Async reset with a pending JAL update: state clears at once, update lost
        @(negedge i_clk);
        drive(1, JAL, 3'd0, 32'h0, 32'h0, 32'h80, 0, 0, 0, 0, 32'h0);
        #1;
        i_reset = 1'b1;
        #1;
        check_cnt("mid_reset", 0, 0);
        check_lookup("mid_reset_alias", 32'h40, 0, 32'h44);
        tick();
        @(negedge i_clk);
        i_reset = 1'b0;
        check_lookup("post_reset_jal", 32'h0, 0, 32'h4);
        check_lookup("post_reset_beq", 32'h200, 0, 32'h204);
        check_lookup("post_reset_jalr", 32'h300, 0, 32'h304);
        check_cnt("post_reset", 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
